bf_executor: RTL and testbench

BF_EXECUTOR -- requirements
Module: bf_executor

---
 rtl/bf_executor.sv | 201 ++++++++++++++++++++
 tb/tb_bf_executor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_executor.sv
// Brainfuck instruction executor: fetches ASCII opcodes from a combinational ROM
// and drives an external tape plus byte-wide input/output handshake channels.
module bf_executor (
  input  logic       working_clock,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [7:0] prog_len,
  input  logic [7:0] mem_value,
  output logic [7:0] mem_new_value,
  output logic       mem_set,
  output logic       mem_move,
  output logic       mem_move_dir,
  output logic       mem_roll_back,
  input  logic       mem_available,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       running,
  output logic       done,
  output logic       error
);

  localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] OP_IN    = 8'h2C;  // ','
  localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'

  typedef enum logic [3:0] {
    IDLE, REWIND, FETCH, WAIT_MEM, OUTPUT, INPUT, SCAN_F, SCAN_B, HALT, ERROR
  } state_t;

  state_t     state, state_n;
  logic [7:0] pc, pc_n;
  logic [7:0] depth, depth_n;
  logic [7:0] mem_new_value_n, out_data_n;
  logic       mem_set_n, mem_move_n, mem_move_dir_n, mem_roll_back_n;
  logic       settle;

  // Every entry into REWIND/WAIT_MEM issues a tape pulse, so a visible pulse marks the settle cycle.
  assign settle    = mem_set | mem_move | mem_roll_back;
  assign prog_addr = pc;

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    depth_n         = depth;
    mem_new_value_n = mem_new_value;
    out_data_n      = out_data;
    mem_move_dir_n  = mem_move_dir;
    mem_set_n       = 1'b0;
    mem_move_n      = 1'b0;
    mem_roll_back_n = 1'b0;
    case (state)
      IDLE, HALT, ERROR: begin
        if (start) begin
          pc_n            = 8'd0;
          depth_n         = 8'd0;
          mem_roll_back_n = 1'b1;
          state_n         = REWIND;
        end
      end
      REWIND, WAIT_MEM: begin
        if (!settle && mem_available) state_n = FETCH;
      end
      FETCH: begin
        if (mem_available) begin
          if (pc == prog_len) begin
            state_n = HALT;
          end else begin
            case (prog_data)
              OP_INC, OP_DEC: begin
                mem_new_value_n = (prog_data == OP_INC) ? mem_value + 8'd1 : mem_value - 8'd1;
                mem_set_n       = 1'b1;
                pc_n            = pc + 8'd1;
                state_n         = WAIT_MEM;
              end
              OP_RIGHT, OP_LEFT: begin
                mem_move_n     = 1'b1;
                mem_move_dir_n = (prog_data == OP_RIGHT);
                pc_n           = pc + 8'd1;
                state_n        = WAIT_MEM;
              end
              OP_OUT: begin
                out_data_n = mem_value;
                state_n    = OUTPUT;
              end
              OP_IN: state_n = INPUT;
              OP_OPEN: begin
                pc_n = pc + 8'd1;
                if (mem_value == 8'd0) begin
                  depth_n = 8'd1;
                  state_n = SCAN_F;
                end
              end
              OP_CLOSE: begin
                if (mem_value == 8'd0) begin
                  pc_n = pc + 8'd1;
                end else if (pc == 8'd0) begin
                  state_n = ERROR;
                end else begin
                  depth_n = 8'd1;
                  pc_n    = pc - 8'd1;
                  state_n = SCAN_B;
                end
              end
              default: pc_n = pc + 8'd1;
            endcase
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          pc_n    = pc + 8'd1;
          state_n = FETCH;
        end
      end
      INPUT: begin
        if (in_valid) begin
          mem_new_value_n = in_data;
          mem_set_n       = 1'b1;
          pc_n            = pc + 8'd1;
          state_n         = WAIT_MEM;
        end
      end
      SCAN_F: begin
        if (pc == prog_len) begin
          state_n = ERROR;
        end else if (prog_data == OP_OPEN && depth == 8'hFF) begin
          state_n = ERROR;
        end else if (prog_data == OP_CLOSE && depth == 8'd1) begin
          depth_n = 8'd0;
          pc_n    = pc + 8'd1;
          state_n = FETCH;
        end else begin
          if (prog_data == OP_OPEN)       depth_n = depth + 8'd1;
          else if (prog_data == OP_CLOSE) depth_n = depth - 8'd1;
          pc_n = pc + 8'd1;
        end
      end
      SCAN_B: begin
        if (prog_data == OP_CLOSE && depth == 8'hFF) begin
          state_n = ERROR;
        end else if (prog_data == OP_OPEN && depth == 8'd1) begin
          depth_n = 8'd0;
          pc_n    = pc + 8'd1;
          state_n = FETCH;
        end else begin
          if (prog_data == OP_CLOSE)     depth_n = depth + 8'd1;
          else if (prog_data == OP_OPEN) depth_n = depth - 8'd1;
          if (pc == 8'd0) state_n = ERROR;
          else            pc_n    = pc - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge working_clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= 8'd0;
      depth         <= 8'd0;
      mem_new_value <= 8'd0;
      out_data      <= 8'd0;
      mem_set       <= 1'b0;
      mem_move      <= 1'b0;
      mem_move_dir  <= 1'b0;
      mem_roll_back <= 1'b0;
      out_valid     <= 1'b0;
      in_ready      <= 1'b0;
      running       <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      depth         <= depth_n;
      mem_new_value <= mem_new_value_n;
      out_data      <= out_data_n;
      mem_set       <= mem_set_n;
      mem_move      <= mem_move_n;
      mem_move_dir  <= mem_move_dir_n;
      mem_roll_back <= mem_roll_back_n;
      out_valid     <= (state_n == OUTPUT);
      in_ready      <= (state_n == INPUT);
      running       <= !(state_n inside {IDLE, HALT, ERROR});
      done          <= (state_n == HALT);
      error         <= (state_n == ERROR);
    end
  end

endmodule

// File: tb/tb_bf_executor.sv
// Bench for bf_executor: tape model, directed programs and random programs
// compared against a plain Brainfuck interpreter.
module tb_bf_executor;
  logic       working_clock = 1'b0;
  logic       reset, start;
  logic [7:0] prog_addr, prog_data, prog_len;
  logic [7:0] mem_value, mem_new_value;
  logic       mem_set, mem_move, mem_move_dir, mem_roll_back, mem_available;
  logic [7:0] out_data, in_data;
  logic       out_valid, out_ready, in_valid, in_ready;
  logic       running, done, error;

  bf_executor dut (
    .working_clock(working_clock), .reset(reset), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
    .mem_value(mem_value), .mem_new_value(mem_new_value), .mem_set(mem_set),
    .mem_move(mem_move), .mem_move_dir(mem_move_dir), .mem_roll_back(mem_roll_back),
    .mem_available(mem_available),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .running(running), .done(done), .error(error)
  );

  always #5 working_clock = ~working_clock;

  logic [7:0] prog_mem [0:255];
  assign prog_data = prog_mem[prog_addr];

  // Tape: 16 cells, refuses moves past either edge, busy 1-2 cycles per operation.
  logic [7:0] cells [0:15];
  logic [3:0] head;
  logic [2:0] busy;
  assign mem_value     = cells[head];
  assign mem_available = (busy == 3'd0);

  always @(posedge working_clock or posedge reset) begin
    if (reset) begin
      head <= 4'd0;
      busy <= 3'd0;
    end else begin
      if (busy != 3'd0) busy <= busy - 3'd1;
      if (mem_roll_back) begin
        head <= 4'd0;
        for (int i = 0; i < 16; i++) cells[i] <= 8'd0;
        busy <= 3'($urandom_range(1, 2));
      end else if (mem_set) begin
        cells[head] <= mem_new_value;
        busy <= 3'($urandom_range(1, 2));
      end else if (mem_move) begin
        if (mem_move_dir && head != 4'd15) head <= head + 4'd1;
        else if (!mem_move_dir && head != 4'd0) head <= head - 4'd1;
        busy <= 3'($urandom_range(1, 2));
      end
    end
  end

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] in_q [$];
  logic [7:0] exp_out [$];
  logic [7:0] got_out [$];
  int         exp_sets;
  bit         exp_halt, exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Straightforward interpreter over the program text with a zeroed 16-cell tape.
  task automatic model(input string p);
    logic [7:0] tp [0:15];
    int hd, pc, idx, n, d, j, steps;
    logic [7:0] c;
    for (int i = 0; i < 16; i++) tp[i] = 8'd0;
    hd = 0; pc = 0; idx = 0; n = p.len(); steps = 0;
    exp_out.delete(); exp_sets = 0; exp_halt = 0; exp_err = 0;
    while (steps < 200000) begin
      steps++;
      if (pc == n) begin exp_halt = 1; break; end
      c = p[pc];
      case (c)
        "+": begin tp[hd] = tp[hd] + 8'd1; exp_sets++; pc++; end
        "-": begin tp[hd] = tp[hd] - 8'd1; exp_sets++; pc++; end
        ">": begin if (hd < 15) hd++; pc++; end
        "<": begin if (hd > 0) hd--; pc++; end
        ".": begin exp_out.push_back(tp[hd]); pc++; end
        ",": begin tp[hd] = (idx < in_q.size()) ? in_q[idx] : 8'd0; idx++; exp_sets++; pc++; end
        "[": begin
          if (tp[hd] != 0) pc++;
          else begin
            d = 1; j = pc + 1;
            while (j < n && d != 0) begin
              if (p[j] == "[") d++; else if (p[j] == "]") d--;
              j++;
            end
            if (d != 0) begin exp_err = 1; break; end
            pc = j;
          end
        end
        "]": begin
          if (tp[hd] == 0) pc++;
          else begin
            d = 1; j = pc - 1;
            while (j >= 0 && d != 0) begin
              if (p[j] == "]") d++; else if (p[j] == "[") d--;
              j--;
            end
            if (d != 0) begin exp_err = 1; break; end
            pc = j + 2;
          end
        end
        default: pc++;
      endcase
    end
  endtask

  task automatic load(input string p);
    for (int i = 0; i < p.len(); i++) prog_mem[i] = p[i];
    prog_len = 8'(p.len());
  endtask

  task automatic pulse_start();
    @(posedge working_clock); #1 start = 1'b1;
    @(posedge working_clock); #1 start = 1'b0;
  endtask

  task automatic run_prog(input string p, input int rdy_pct);
    int  idx, cyc, sets, viol;
    bit  held;
    logic [7:0] held_data;
    load(p);
    model(p);
    got_out.delete();
    idx = 0; cyc = 0; sets = 0; viol = 0; held = 0; held_data = 8'd0;
    pulse_start();
    check($sformatf("%s rollback+running", p), {30'd0, mem_roll_back, running}, 32'd3);
    while (!(done || error) && cyc < 6000) begin
      if (mem_set) sets++;
      if (int'(mem_set) + int'(mem_move) + int'(mem_roll_back) > 1) viol++;
      if ((mem_set || mem_move || mem_roll_back) && !mem_available) viol++;
      if (held && (!out_valid || out_data != held_data)) viol++;
      in_data   = (idx < in_q.size()) ? in_q[idx] : 8'd0;
      in_valid  = ($urandom_range(0, 99) < rdy_pct);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (out_valid && out_ready) got_out.push_back(out_data);
      if (in_ready && in_valid) idx++;
      held = out_valid && !out_ready;
      held_data = out_data;
      @(posedge working_clock); #1;
      cyc++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check({p, " finished in bound"}, 32'(cyc < 6000), 32'd1);
    check({p, " done"}, {31'd0, done}, {31'd0, exp_halt});
    check({p, " error"}, {31'd0, error}, {31'd0, exp_err});
    check({p, " running"}, {31'd0, running}, 32'd0);
    check({p, " output count"}, 32'(got_out.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size(); i++)
      check($sformatf("%s out[%0d]", p, i), (i < got_out.size()) ? {24'd0, got_out[i]} : 32'hDEAD, {24'd0, exp_out[i]});
    check({p, " mem_set count"}, 32'(sets), 32'(exp_sets));
    check({p, " pulse protocol"}, 32'(viol), 32'd0);
  endtask

  function automatic string gen_prog();
    string toks [9] = '{"+", "-", ">", "<", ".", ",", "x", "[-]", "+[-]"};
    string p = "";
    int n = $urandom_range(3, 14);
    for (int i = 0; i < n; i++) p = {p, toks[$urandom_range(0, 8)]};
    return {p, "."};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " data outputs"}, {8'd0, prog_addr, mem_new_value, out_data}, 32'd0);
    check({tag, " flag outputs"}, {23'd0, mem_set, mem_move, mem_move_dir, mem_roll_back,
                                   in_ready, out_valid, running, done, error}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int k;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    prog_len = 8'd0;
    for (int i = 0; i < 256; i++) prog_mem[i] = 8'd0;
    for (int i = 0; i < 64; i++) in_q.push_back(8'($urandom_range(0, 40)));
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    @(posedge working_clock); #1 reset = 1'b0;
    check_all_zero("after reset");

    run_prog("+++.", 100);
    run_prog("-.", 100);
    in_q[0] = 8'h41;
    run_prog(",.", 100);
    run_prog("++[-].", 100);
    run_prog("[+].", 100);
    run_prog("[", 100);
    run_prog("+]", 100);
    run_prog("+>>+<]x[.", 60);

    // Output held off for five cycles
    load(".");
    out_ready = 1'b0;
    pulse_start();
    k = 0;
    while (!out_valid && k < 50) begin @(posedge working_clock); #1; k++; end
    check("hold out_valid seen", {31'd0, out_valid}, 32'd1);
    d = out_data;
    check("hold out_data value", {24'd0, d}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold out_valid c%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold out_data c%0d", i), {24'd0, out_data}, {24'd0, d});
      check($sformatf("hold pc c%0d", i), {24'd0, prog_addr}, 32'd0);
      @(posedge working_clock); #1;
    end
    out_ready = 1'b1;
    @(posedge working_clock); #1 out_ready = 1'b0;
    check("hold released out_valid", {31'd0, out_valid}, 32'd0);
    check("hold released pc", {24'd0, prog_addr}, 32'd1);
    k = 0;
    while (!done && k < 50) begin @(posedge working_clock); #1; k++; end
    check("hold done", {31'd0, done}, 32'd1);

    // Reset in the wait after a move
    load(">");
    pulse_start();
    k = 0;
    while (!mem_move && k < 50) begin @(posedge working_clock); #1; k++; end
    check("move issued", {31'd0, mem_move}, 32'd1);
    reset = 1'b1;
    #1 check_all_zero("mid-run reset");
    @(posedge working_clock); #1 reset = 1'b0;
    check_all_zero("post reset edge");
    repeat (3) @(posedge working_clock);
    #1 check("idle waits for start", {31'd0, running}, 32'd0);
    pulse_start();
    check("restart rollback", {30'd0, mem_roll_back, running}, 32'd3);
    check("restart pc", {24'd0, prog_addr}, 32'd0);
    k = 0;
    while (!done && k < 50) begin @(posedge working_clock); #1; k++; end
    check("restart done", {31'd0, done}, 32'd1);

    for (int r = 0; r < 15; r++) begin
      in_q.delete();
      for (int i = 0; i < 64; i++) in_q.push_back(8'($urandom_range(0, 255)));
      run_prog(gen_prog(), $urandom_range(30, 100));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
